// File: rtl/mcr_spin_encoder.sv
// mcr_spin_encoder
// Frame-rate spinner emulator for the MCR2 input ports. Rotate buttons or one
// analog stick axis are sampled once per video frame (vsync rising edge) and
// turned into a signed step. Held buttons ramp up through a hold-time
// acceleration curve. The step is accumulated into a wrapping 8-bit angle.
//
// Ports:
//   clock_40    in   1  system clock (40 MHz)
//   reset_n     in   1  asynchronous active-low reset
//   vsync       in   1  asynchronous frame pulse, one tick per rising edge
//   btn_left    in   1  rotate counter-clockwise (decrement)
//   btn_right   in   1  rotate clockwise (increment)
//   btn_acc     in   1  1 = button acceleration, 0 = fixed step of 1
//   use_analog  in   1  1 = analog_x drives the step outside the deadzone
//   analog_x    in   8  signed stick axis, negative = left
//   spin_angle  out  8  accumulated position, modulo 256
//   spin_dir    out  1  direction of the last non-zero step (1 = right)
//   moving      out  1  last frame tick applied a non-zero step
module mcr_spin_encoder #(
  parameter int ACC_MAX  = 15,
  parameter int ACC_RATE = 4,
  parameter int DEADZONE = 8
) (
  input  logic       clock_40,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_acc,
  input  logic       use_analog,
  input  logic [7:0] analog_x,
  output logic [7:0] spin_angle,
  output logic       spin_dir,
  output logic       moving
);

  localparam logic [3:0] LP_ACC_MAX  = 4'(ACC_MAX);
  localparam logic [3:0] LP_RATE_M1  = 4'(ACC_RATE - 1);
  localparam logic [8:0] LP_DZ       = 9'(DEADZONE);
  localparam logic [8:0] LP_MAX_WIDE = 9'(ACC_MAX);

  // Saturating +1 on the button speed, capped at ACC_MAX.
  function automatic logic [3:0] f_speed_inc(input logic [3:0] speed);
    logic [3:0] res;
    if (speed >= LP_ACC_MAX) begin
      res = LP_ACC_MAX;
    end else begin
      res = speed + 4'd1;
    end
    return res;
  endfunction

  logic       r_vs_sync1;
  logic       r_vs_sync2;
  logic       r_vs_hist;
  logic [7:0] r_angle;
  logic       r_dir;
  logic       r_moving;
  logic [3:0] r_speed;
  logic [3:0] r_frame_cnt;

  logic       w_tick;
  logic [8:0] w_mag;
  logic [8:0] w_mag_shr;
  logic       w_analog_act;
  logic [3:0] w_step_analog;
  logic [3:0] w_step;
  logic       w_dir_req;
  logic [3:0] w_speed_nxt;
  logic [3:0] w_frame_cnt_nxt;
  logic [7:0] w_angle_nxt;

  // vsync synchronizer and edge history; all ones at reset so a vsync held
  // high through reset release never looks like a rising edge.
  always_ff @(posedge clock_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_sync1 <= 1'b1;
      r_vs_sync2 <= 1'b1;
      r_vs_hist  <= 1'b1;
    end else begin
      r_vs_sync1 <= vsync;
      r_vs_sync2 <= r_vs_sync1;
      r_vs_hist  <= r_vs_sync2;
    end
  end

  assign w_tick = r_vs_sync2 & ~r_vs_hist;

  // Analog magnitude is 9 bits wide so that -128 maps to +128.
  always_comb begin
    w_mag         = 9'd0;
    w_step_analog = 4'd0;
    if (analog_x[7]) begin
      w_mag = 9'd0 - {analog_x[7], analog_x};
    end else begin
      w_mag = {1'b0, analog_x};
    end
    w_mag_shr = w_mag >> 3;
    if (w_mag_shr > LP_MAX_WIDE) begin
      w_step_analog = LP_ACC_MAX;
    end else begin
      w_step_analog = w_mag_shr[3:0];
    end
    w_analog_act = use_analog && (w_mag > LP_DZ);
  end

  // Per-frame step, direction and acceleration-state update.
  always_comb begin
    w_step          = 4'd0;
    w_dir_req       = r_dir;
    w_speed_nxt     = r_speed;
    w_frame_cnt_nxt = r_frame_cnt;
    if (w_analog_act) begin
      // Stick overrides the buttons and cancels any button ramp.
      w_step          = w_step_analog;
      w_dir_req       = ~analog_x[7];
      w_speed_nxt     = 4'd1;
      w_frame_cnt_nxt = 4'd0;
    end else if (btn_left ^ btn_right) begin
      w_dir_req = btn_right;
      if (r_moving && (btn_right != r_dir)) begin
        // Reversal: one slow step, ramp restarts from scratch.
        w_step          = 4'd1;
        w_speed_nxt     = 4'd1;
        w_frame_cnt_nxt = 4'd0;
      end else begin
        if (btn_acc) begin
          w_step = r_speed;
        end else begin
          w_step = 4'd1;
        end
        if (r_frame_cnt == LP_RATE_M1) begin
          w_frame_cnt_nxt = 4'd0;
          w_speed_nxt     = f_speed_inc(r_speed);
        end else begin
          w_frame_cnt_nxt = r_frame_cnt + 4'd1;
          w_speed_nxt     = r_speed;
        end
      end
    end else begin
      w_step          = 4'd0;
      w_speed_nxt     = 4'd1;
      w_frame_cnt_nxt = 4'd0;
    end

    if (w_dir_req) begin
      w_angle_nxt = r_angle + {4'd0, w_step};
    end else begin
      w_angle_nxt = r_angle - {4'd0, w_step};
    end
  end

  // Position, direction and acceleration registers advance only on a tick.
  always_ff @(posedge clock_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_angle     <= 8'd0;
      r_dir       <= 1'b0;
      r_moving    <= 1'b0;
      r_speed     <= 4'd1;
      r_frame_cnt <= 4'd0;
    end else if (w_tick) begin
      r_angle     <= w_angle_nxt;
      r_moving    <= (w_step != 4'd0);
      r_speed     <= w_speed_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      if (w_step != 4'd0) begin
        r_dir <= w_dir_req;
      end else begin
        r_dir <= r_dir;
      end
    end else begin
      r_angle     <= r_angle;
      r_dir       <= r_dir;
      r_moving    <= r_moving;
      r_speed     <= r_speed;
      r_frame_cnt <= r_frame_cnt;
    end
  end

  assign spin_angle = r_angle;
  assign spin_dir   = r_dir;
  assign moving     = r_moving;

endmodule

// File: tb/tb_mcr_spin_encoder.sv
// Bench for mcr_spin_encoder: directed scenarios plus randomized frames,
// checked every cycle against a frame-level behavioural model.
module tb_mcr_spin_encoder;

  localparam int ACC_MAX  = 15;
  localparam int ACC_RATE = 4;
  localparam int DEADZONE = 8;

  logic       clock_40;
  logic       reset_n;
  logic       vsync;
  logic       btn_left;
  logic       btn_right;
  logic       btn_acc;
  logic       use_analog;
  logic [7:0] analog_x;
  logic [7:0] spin_angle;
  logic       spin_dir;
  logic       moving;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // model state: angle, last direction, moving flag, accelerating-frame run length
  int m_angle  = 0;
  int m_dir    = 0;
  int m_moving = 0;
  int m_run    = 0;

  mcr_spin_encoder #(
    .ACC_MAX (ACC_MAX),
    .ACC_RATE(ACC_RATE),
    .DEADZONE(DEADZONE)
  ) dut (
    .clock_40  (clock_40),
    .reset_n   (reset_n),
    .vsync     (vsync),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_acc   (btn_acc),
    .use_analog(use_analog),
    .analog_x  (analog_x),
    .spin_angle(spin_angle),
    .spin_dir  (spin_dir),
    .moving    (moving)
  );

  initial begin
    clock_40 = 1'b0;
    forever #5 clock_40 = ~clock_40;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on the falling edge.
  always @(negedge clock_40) begin
    if (chk_en) begin
      check("angle", int'(spin_angle), m_angle);
      check("dir", int'(spin_dir), m_dir);
      check("moving", int'(moving), m_moving);
    end
  end

  task automatic model_reset();
    m_angle  = 0;
    m_dir    = 0;
    m_moving = 0;
    m_run    = 0;
  endtask

  // One frame tick of the spinner, from the behavioural rules.
  task automatic model_tick(input logic l, input logic r, input logic acc,
                            input logic ua, input logic [7:0] ax);
    int sx;
    int mag;
    int step;
    int dir_req;
    sx = int'($signed(ax));
    mag = (sx < 0) ? -sx : sx;
    step = 0;
    dir_req = m_dir;
    if (ua && mag > DEADZONE) begin
      step = mag / 8;
      if (step > ACC_MAX) step = ACC_MAX;
      dir_req = (sx < 0) ? 0 : 1;
      m_run = 0;
    end else if (l != r) begin
      dir_req = r ? 1 : 0;
      if (m_moving != 0 && dir_req != m_dir) begin
        step = 1;
        m_run = 0;
      end else begin
        if (acc) begin
          step = 1 + m_run / ACC_RATE;
          if (step > ACC_MAX) step = ACC_MAX;
        end else begin
          step = 1;
        end
        m_run++;
      end
    end else begin
      step = 0;
      m_run = 0;
    end
    m_angle = (m_angle + (dir_req != 0 ? step : -step)) & 255;
    m_moving = (step != 0) ? 1 : 0;
    if (step != 0) m_dir = dir_req;
  endtask

  // Called just after a rising clock edge. Drives one frame with the given
  // controls, then scrambles the buttons between ticks.
  task automatic do_frame(input logic l, input logic r, input logic acc,
                          input logic ua, input logic [7:0] ax);
    btn_left   = l;
    btn_right  = r;
    btn_acc    = acc;
    use_analog = ua;
    analog_x   = ax;
    vsync      = 1'b1;
    repeat (3) @(posedge clock_40);
    model_tick(l, r, acc, ua, ax);
    @(posedge clock_40);
    #1;
    vsync      = 1'b0;
    btn_left   = 1'($urandom_range(0, 1));
    btn_right  = 1'($urandom_range(0, 1));
    use_analog = 1'($urandom_range(0, 1));
    analog_x   = 8'($urandom_range(0, 255));
    repeat (4) @(posedge clock_40);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clock_40);
    #1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock_40);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock_40);
    #1;
  endtask

  initial begin
    logic l_r;
    logic r_r;
    logic acc_r;
    logic ua_r;
    logic [7:0] ax_r;

    reset_n    = 1'b0;
    vsync      = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_acc    = 1'b0;
    use_analog = 1'b0;
    analog_x   = 8'd0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clock_40);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock_40);
    #1;
    check("reset_angle", int'(spin_angle), 0);
    check("reset_moving", int'(moving), 0);

    // idle frames
    repeat (3) do_frame(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    check("idle_angle", int'(spin_angle), 0);
    check("idle_moving", int'(moving), 0);
    check("idle_dir", int'(spin_dir), 0);

    // acceleration ramp: 1,1,1,1,2,2,2,2,3,3,3,3
    repeat (12) do_frame(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check("ramp12_angle", int'(spin_angle), 24);
    check("ramp12_dir", int'(spin_dir), 1);

    // fixed step, wrap below zero, reversal
    apply_reset();
    do_frame(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (3) do_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    check("left3_angle", int'(spin_angle), 254);
    check("left3_dir", int'(spin_dir), 0);
    do_frame(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("reverse_angle", int'(spin_angle), 255);

    // analog full left, then deadzone falls back to buttons
    apply_reset();
    repeat (2) do_frame(1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
    check("analog_angle", int'(spin_angle), 226);
    do_frame(1'b0, 1'b1, 1'b1, 1'b1, 8'd8);
    check("deadzone_angle", int'(spin_angle), 227);
    check("deadzone_dir", int'(spin_dir), 1);

    // long hold saturates at ACC_MAX and wraps through 0
    apply_reset();
    repeat (100) do_frame(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check("hold100_angle", int'(spin_angle), 56);
    do_frame(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    check("both_moving", int'(moving), 0);
    check("both_angle", int'(spin_angle), 56);

    // vsync held high across reset release gives no tick
    @(posedge clock_40);
    #1;
    reset_n = 1'b0;
    model_reset();
    vsync = 1'b1;
    btn_right = 1'b1;
    btn_left = 1'b0;
    use_analog = 1'b0;
    repeat (3) @(posedge clock_40);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clock_40);
    #1;
    check("nospur_angle", int'(spin_angle), 0);
    check("nospur_moving", int'(moving), 0);
    vsync = 1'b0;
    repeat (4) @(posedge clock_40);
    #1;

    // reset asserted mid-hold clears outputs immediately, tick is lost
    repeat (3) do_frame(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check("prehold_angle", int'(spin_angle), 3);
    btn_left = 1'b0;
    btn_right = 1'b1;
    use_analog = 1'b0;
    vsync = 1'b1;
    @(posedge clock_40);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_angle", int'(spin_angle), 0);
    check("async_dir", int'(spin_dir), 0);
    check("async_moving", int'(moving), 0);
    @(posedge clock_40);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clock_40);
    #1;
    check("lost_tick_angle", int'(spin_angle), 0);
    vsync = 1'b0;
    repeat (4) @(posedge clock_40);
    #1;

    // randomized frames with sticky controls so ramps build up
    l_r = 1'b0; r_r = 1'b1; acc_r = 1'b1; ua_r = 1'b0; ax_r = 8'd0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        l_r   = 1'($urandom_range(0, 1));
        r_r   = 1'($urandom_range(0, 1));
        acc_r = ($urandom_range(0, 3) != 0);
        ua_r  = ($urandom_range(0, 2) == 0);
        ax_r  = 8'($urandom_range(0, 255));
      end
      do_frame(l_r, r_r, acc_r, ua_r, ax_r);
    end

    repeat (2) @(posedge clock_40);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcr_spin_encoder.md
# mcr_spin_encoder

Frame-rate spinner emulator that converts digital rotate buttons, or one analog stick axis, into the 8-bit wrapping angle count that the MCR2 game input ports read; Tron, Two Tigers and Krooz'r take bits [7:1] of it. It sits upstream of the game core's input mux, one instance per spinner. It samples controls once per video frame, on the vsync rising edge. It applies a hold-time acceleration curve and accumulates a modulo-256 position.

## Interface
Parameters:
- ACC_MAX, default 15: maximum step per frame (1..15).
- ACC_RATE, default 4: number of held frames per +1 speed increment (1..15).
- DEADZONE, default 8: analog magnitude at or below which the stick is treated as centred.

Ports:
- clock_40  in  1  system clock (40 MHz); one clock only.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  asynchronous frame pulse; each rising edge is one frame tick.
- btn_left  in  1  rotate counter-clockwise (decrement).
- btn_right  in  1  rotate clockwise (increment).
- btn_acc  in  1  1 = button acceleration enabled, 0 = fixed step of 1.
- use_analog  in  1  1 = analog_x drives the step when outside the deadzone.
- analog_x  in  8  signed two's-complement stick axis; negative means left.
- spin_angle  out  8  accumulated position, modulo 256.
- spin_dir  out  1  direction of the last non-zero step (1 = right).
- moving  out  1  1 if the last frame tick applied a non-zero step.

## Operation
- vsync passes through a 2-flop synchronizer plus a history flop; all three reset to 1. tick = sync2 & ~hist. A vsync held high through reset release produces no tick.
- Analog path is active when use_analog=1 and |analog_x| > DEADZONE.
  - mag = |analog_x| (9-bit internal, so -128 gives 128).
  - step = min(mag >> 3, ACC_MAX); sign taken from analog_x[7].
  - The analog path overrides the buttons completely.
  - speed and frame_cnt reset to 1 and 0 while analog is active.
- Button path applies when the analog path is inactive:
  - Exactly one of btn_left/btn_right held: step = btn_acc ? speed : 1.
  - Both held or none held: step = 0, speed := 1, frame_cnt := 0.
  - Direction differs from spin_dir while moving=1 (a reversal): this frame uses step 1, speed := 1, frame_cnt := 0.
  - Otherwise, when held: frame_cnt increments. When frame_cnt reaches ACC_RATE-1 it wraps to 0 and speed := min(speed+1, ACC_MAX).
- Update on each tick:
  - spin_angle := spin_angle ± step, 8-bit, wraps silently (255+1 = 0, 0-1 = 255).
  - moving := (step != 0).
  - spin_dir updates only when step != 0.
- Controls are sampled only on a tick; button activity between ticks is ignored.
- Reset values: spin_angle=0, spin_dir=0, moving=0, speed=1, frame_cnt=0.

## Timing
- vsync rises before clock edge N → sync1 at N, sync2 at N+1, tick is high during the cycle after N+1 → outputs update at edge N+2. Latency is 2–3 clocks depending on vsync phase.
- tick lasts exactly one clock per vsync rising edge, regardless of vsync pulse width. Minimum vsync high and low time is 3 clocks.
- Outputs are registered; they change only on tick cycles or on reset.
- reset_n assertion clears all state immediately; the output equals the reset values asynchronously. A tick coinciding with reset release is lost.
- btn_left, btn_right, analog_x and use_analog are sampled with the tick. They are expected to be quasi-static (synchronous to clock_40 or slow-changing).

## Test plan
- Reset, then 3 vsync pulses with no input → spin_angle=0, moving=0, spin_dir=0.
- btn_acc=1, ACC_RATE=4, hold btn_right for 12 frames → steps 1,1,1,1,2,2,2,2,3,3,3,3; spin_angle=24, spin_dir=1.
- btn_acc=0, hold btn_left 3 frames from 1 → spin_angle=254; then hold btn_right 1 frame → step 1 (reversal), spin_angle=255.
- use_analog=1, analog_x=-128 for 2 frames, ACC_MAX=15 → step -15 each frame, spin_angle=226. analog_x=8 (deadzone) with btn_right held → button path used, step 1.
- Hold btn_right with ACC_MAX=15 for 100 frames → step saturates at 15; spin_angle wraps through 0 with no glitch. A both-buttons frame gives step 0 and moving=0.
- vsync high across reset release, then assert reset_n low mid-hold → no spurious tick after release; the assertion forces all outputs to 0 within the same cycle.
